// File: rtl/mm_stage.sv
// mm_stage: memory-access stage that receives result packets, performs load/store on a local data memory and forwards results downstream.
// Ports:
//   cp, MR              clock (rising edge), asynchronous active-high master reset
//   Send_in, Ack_out    upstream handshake; a packet transfers on Send_in & Ack_out at rising cp
//   PACKET_IN[39:0]     {col[3], gen[8], node[7], LR[2], rsvd[2], C, Z, data/addr[16]}
//   LOAD_FLG, WRITE_EN  load / store request (store wins when both are set); address = PACKET_IN[15:0]
//   WRITE_DATA[15:0]    store data
//   Send_out, Ack_in    downstream handshake; a packet transfers on Send_out & Ack_in at rising cp
//   PACKET_OUT[39:0]    result packet, same layout as PACKET_IN
//   ERR                 sticky error flag (bad address or both request flags), cleared only by MR
// Configuration macro: MM_STORE_ACK_EN -- when defined, a store emits an ack packet carrying WRITE_DATA.
module mm_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        cp,
  input  logic        MR,
  input  logic        Send_in,
  output logic        Ack_out,
  input  logic [39:0] PACKET_IN,
  input  logic        LOAD_FLG,
  input  logic        WRITE_EN,
  input  logic [15:0] WRITE_DATA,
  output logic        Send_out,
  input  logic        Ack_in,
  output logic [39:0] PACKET_OUT,
  output logic        ERR
);
  typedef enum logic [1:0] {IDLE, RD, WR, OUT} state_t;
`ifdef MM_STORE_ACK_EN
  localparam bit STORE_ACK = 1'b1;
`else
  localparam bit STORE_ACK = 1'b0;
`endif
  state_t            state, next;
  logic [15:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata, rdata;
  logic              ok, xfer, in_ok, in_err;
  assign Ack_out  = (state == IDLE) & ~MR;
  assign Send_out = state == OUT;
  assign xfer     = Send_in & Ack_out;
  // address is in range when no bits above the memory index are set
  assign in_ok    = (PACKET_IN[15:0] >> ADDR_W) == 16'h0;
  // the range check only matters for memory requests; pass-through data is not an address
  assign in_err   = ((LOAD_FLG | WRITE_EN) & ~in_ok) | (LOAD_FLG & WRITE_EN);
  // out-of-range loads return zero
  assign rdata    = ok ? mem[addr] : 16'h0;
  always_ff @(posedge cp or posedge MR) begin
    if (MR) state <= IDLE;
    else    state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !xfer ? IDLE : WRITE_EN ? WR : LOAD_FLG ? RD : OUT;
      RD:      next = OUT;
      WR:      next = STORE_ACK ? OUT : IDLE;
      OUT:     next = Ack_in ? IDLE : OUT;
      default: next = IDLE;
    endcase
  end
  // header fields [39:18] are captured at accept; RD/WR only rewrite C, Z and data
  always_ff @(posedge cp or posedge MR) begin
    if (MR) begin
      PACKET_OUT <= '0;
      ERR        <= 1'b0;
      addr       <= '0;
      ok         <= 1'b0;
      wdata      <= '0;
    end else begin
      if (xfer) begin
        PACKET_OUT <= PACKET_IN;
        addr       <= PACKET_IN[ADDR_W-1:0];
        ok         <= in_ok;
        wdata      <= WRITE_DATA;
        if (in_err) ERR <= 1'b1;
      end
      if (state == RD) PACKET_OUT[17:0] <= {1'b0, rdata == 16'h0, rdata};
      if (state == WR && STORE_ACK) PACKET_OUT[17:0] <= {1'b0, wdata == 16'h0, wdata};
    end
  end
  // MR forces state to IDLE asynchronously, so a store cut short by MR never reaches this write
  always_ff @(posedge cp) begin
    if (state == WR && ok) mem[addr] <= wdata;
  end
endmodule

// File: tb/tb_mm_stage.sv
// tb_mm_stage: directed self-checking bench for mm_stage (table-driven vectors plus multi-cycle sequences).
module tb_mm_stage;
`ifdef MM_STORE_ACK_EN
  localparam bit SA = 1'b1;
`else
  localparam bit SA = 1'b0;
`endif
  localparam int SL = SA ? 2 : 0;
  logic        cp, MR, Send_in, Ack_out, LOAD_FLG, WRITE_EN, Send_out, Ack_in, ERR;
  logic [39:0] PACKET_IN, PACKET_OUT;
  logic [15:0] WRITE_DATA;
  int          n_tests = 0, n_fail = 0;
  mm_stage #(.ADDR_W(8)) dut (
    .cp(cp), .MR(MR), .Send_in(Send_in), .Ack_out(Ack_out), .PACKET_IN(PACKET_IN),
    .LOAD_FLG(LOAD_FLG), .WRITE_EN(WRITE_EN), .WRITE_DATA(WRITE_DATA),
    .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT), .ERR(ERR)
  );
  initial cp = 1'b0;
  always #5 cp = ~cp;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  typedef struct {
    bit          rst;
    logic [39:0] pkt;
    logic        ld;
    logic        we;
    logic [15:0] wd;
    int          lat;
    logic [39:0] exp;
    logic        err;
    int          hold;
  } vec_t;
  function automatic logic [39:0] mk(logic [2:0] col, logic [7:0] gen, logic [6:0] node,
                                     logic [1:0] lr, logic c, logic z, logic [15:0] d);
    return {col, gen, node, lr, 2'b00, c, z, d};
  endfunction
  function automatic logic [39:0] res(logic [39:0] p, logic [15:0] d);
    return {p[39:18], 1'b0, d == 16'h0, d};
  endfunction
  task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(int idx, vec_t v);
    int n;
    if (v.rst) begin
      @(negedge cp);
      MR = 1'b1;
      @(negedge cp);
      chk($sformatf("v%0d rst_err", idx), 40'(ERR), 40'h0);
      chk($sformatf("v%0d rst_pkt", idx), PACKET_OUT, 40'h0);
      MR = 1'b0;
    end
    @(negedge cp);
    n = 0;
    while (!Ack_out && n < 10) begin
      @(negedge cp);
      n++;
    end
    chk($sformatf("v%0d ready", idx), 40'(Ack_out), 40'h1);
    PACKET_IN  = v.pkt;
    LOAD_FLG   = v.ld;
    WRITE_EN   = v.we;
    WRITE_DATA = v.wd;
    Send_in    = 1'b1;
    @(negedge cp);
    Send_in    = 1'b0;
    LOAD_FLG   = 1'($urandom);
    WRITE_EN   = 1'($urandom);
    WRITE_DATA = 16'($urandom);
    PACKET_IN  = {8'($urandom), 32'($urandom)};
    n = 1;
    while (!Send_out && n < 4) begin
      @(negedge cp);
      n++;
    end
    chk($sformatf("v%0d latency", idx), Send_out ? 40'(n) : 40'h0, 40'(v.lat));
    if (v.lat != 0) chk($sformatf("v%0d packet", idx), PACKET_OUT, v.exp);
    chk($sformatf("v%0d err", idx), 40'(ERR), 40'(v.err));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge cp);
      chk($sformatf("v%0d hold_pkt", idx), PACKET_OUT, v.exp);
      chk($sformatf("v%0d hold_send", idx), 40'(Send_out), 40'h1);
      chk($sformatf("v%0d hold_ack_out", idx), 40'(Ack_out), 40'h0);
    end
    if (Send_out) begin
      Ack_in = 1'b1;
      @(negedge cp);
      Ack_in = 1'b0;
    end
  endtask
  vec_t        tv[13];
  logic [15:0] mref [256];
  logic [39:0] q[$];
  logic [39:0] bp[8];
  logic        bld[8], bwe[8];
  logic [15:0] bwd[8];
  bit          drv_done;
  initial begin
    MR = 1'b1; Send_in = 1'b0; Ack_in = 1'b0; LOAD_FLG = 1'b0; WRITE_EN = 1'b0;
    WRITE_DATA = 16'h0; PACKET_IN = 40'h0;
    tv[0]  = '{0, mk(1, 8'h10, 7'h01, 2'd0, 0, 0, 16'h0012), 0, 1, 16'hBEEF, SL, mk(1, 8'h10, 7'h01, 2'd0, 0, 0, 16'hBEEF), 0, 0};
    tv[1]  = '{0, mk(3, 8'h5A, 7'h11, 2'd2, 1, 1, 16'h0012), 1, 0, 16'h0000, 2,  mk(3, 8'h5A, 7'h11, 2'd2, 0, 0, 16'hBEEF), 0, 0};
    tv[2]  = '{0, 40'h12_3456_789A,                          0, 0, 16'h0000, 1,  40'h12_3456_789A,                          0, 5};
    tv[3]  = '{0, mk(0, 8'h00, 7'h00, 2'd0, 0, 0, 16'h0000), 0, 1, 16'h1234, SL, mk(0, 8'h00, 7'h00, 2'd0, 0, 0, 16'h1234), 0, 0};
    tv[4]  = '{0, mk(7, 8'hFF, 7'h7F, 2'd3, 0, 0, 16'h0000), 1, 0, 16'h0000, 2,  mk(7, 8'hFF, 7'h7F, 2'd3, 0, 0, 16'h1234), 0, 0};
    tv[5]  = '{0, mk(2, 8'h22, 7'h22, 2'd1, 0, 0, 16'h00FF), 0, 1, 16'h00A5, SL, mk(2, 8'h22, 7'h22, 2'd1, 0, 0, 16'h00A5), 0, 0};
    tv[6]  = '{0, mk(2, 8'h33, 7'h33, 2'd1, 0, 0, 16'h00FF), 1, 0, 16'h0000, 2,  mk(2, 8'h33, 7'h33, 2'd1, 0, 0, 16'h00A5), 0, 0};
    tv[7]  = '{0, mk(4, 8'h44, 7'h44, 2'd0, 0, 0, 16'h0100), 1, 0, 16'h0000, 2,  mk(4, 8'h44, 7'h44, 2'd0, 0, 1, 16'h0000), 1, 0};
    tv[8]  = '{0, mk(5, 8'h55, 7'h55, 2'd0, 0, 0, 16'h0100), 0, 1, 16'hDEAD, SL, mk(5, 8'h55, 7'h55, 2'd0, 0, 0, 16'hDEAD), 1, 0};
    tv[9]  = '{0, mk(6, 8'h66, 7'h66, 2'd0, 0, 0, 16'h0000), 1, 0, 16'h0000, 2,  mk(6, 8'h66, 7'h66, 2'd0, 0, 0, 16'h1234), 1, 0};
    tv[10] = '{0, mk(1, 8'h01, 7'h01, 2'd0, 0, 0, 16'h0007), 0, 1, 16'h5555, SL, mk(1, 8'h01, 7'h01, 2'd0, 0, 0, 16'h5555), 1, 0};
    tv[11] = '{1, mk(1, 8'h02, 7'h02, 2'd0, 0, 0, 16'h0007), 1, 1, 16'h0000, SL, mk(1, 8'h02, 7'h02, 2'd0, 0, 1, 16'h0000), 1, 0};
    tv[12] = '{0, mk(1, 8'h03, 7'h03, 2'd0, 0, 0, 16'h0007), 1, 0, 16'h0000, 2,  mk(1, 8'h03, 7'h03, 2'd0, 0, 1, 16'h0000), 1, 0};
    repeat (2) @(negedge cp);
    chk("reset send_out", 40'(Send_out), 40'h0);
    chk("reset ack_out", 40'(Ack_out), 40'h0);
    chk("reset packet_out", PACKET_OUT, 40'h0);
    chk("reset err", 40'(ERR), 40'h0);
    MR = 1'b0;
    @(negedge cp);
    chk("post-reset ack_out", 40'(Ack_out), 40'h1);
    PACKET_IN = mk(1, 8'h01, 7'h01, 2'd0, 0, 0, 16'h0012);
    LOAD_FLG = 1'b1;
    Send_in = 1'b1;
    @(negedge cp);
    Send_in = 1'b0;
    LOAD_FLG = 1'b0;
    MR = 1'b1;
    #1;
    chk("mid-RD MR send_out", 40'(Send_out), 40'h0);
    chk("mid-RD MR ack_out", 40'(Ack_out), 40'h0);
    @(negedge cp);
    chk("mid-RD MR held send_out", 40'(Send_out), 40'h0);
    chk("mid-RD MR held ack_out", 40'(Ack_out), 40'h0);
    MR = 1'b0;
    @(negedge cp);
    chk("after MR ack_out", 40'(Ack_out), 40'h1);
    chk("after MR send_out", 40'(Send_out), 40'h0);
    chk("after MR err", 40'(ERR), 40'h0);
    for (int i = 0; i < 13; i++) run_vec(i, tv[i]);
    bp[0] = mk(1, 8'hA0, 7'h10, 2'd1, 0, 0, 16'h0020); bld[0] = 0; bwe[0] = 1; bwd[0] = 16'h1111;
    bp[1] = mk(2, 8'hA1, 7'h11, 2'd2, 1, 0, 16'h0020); bld[1] = 1; bwe[1] = 0; bwd[1] = 16'h0000;
    bp[2] = 40'hAB_CDEF_0123;                          bld[2] = 0; bwe[2] = 0; bwd[2] = 16'h7777;
    bp[3] = mk(3, 8'hA3, 7'h13, 2'd0, 0, 0, 16'h0021); bld[3] = 0; bwe[3] = 1; bwd[3] = 16'h0000;
    bp[4] = mk(4, 8'hA4, 7'h14, 2'd3, 0, 0, 16'h0021); bld[4] = 1; bwe[4] = 0; bwd[4] = 16'h0000;
    bp[5] = 40'h55_AAAA_5555;                          bld[5] = 0; bwe[5] = 0; bwd[5] = 16'h0000;
    bp[6] = mk(6, 8'hA6, 7'h16, 2'd1, 0, 1, 16'h0020); bld[6] = 0; bwe[6] = 1; bwd[6] = 16'h2222;
    bp[7] = mk(7, 8'hA7, 7'h17, 2'd2, 0, 0, 16'h0020); bld[7] = 1; bwe[7] = 0; bwd[7] = 16'h0000;
    drv_done = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          int w;
          PACKET_IN = bp[k]; LOAD_FLG = bld[k]; WRITE_EN = bwe[k]; WRITE_DATA = bwd[k]; Send_in = 1'b1;
          w = 0;
          while (!Ack_out && w < 50) begin
            @(negedge cp);
            w++;
          end
          if (w >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL b2b accept %0d: no Ack_out within 50 cycles", k);
          end
          if (bwe[k]) begin
            mref[bp[k][7:0]] = bwd[k];
            if (SA) q.push_back(res(bp[k], bwd[k]));
          end else if (bld[k]) q.push_back(res(bp[k], mref[bp[k][7:0]]));
          else q.push_back(bp[k]);
          @(negedge cp);
        end
        Send_in = 1'b0;
        drv_done = 1;
      end
      begin
        int got, c, n_exp;
        logic [7:0] pat;
        logic [39:0] e;
        pat = 8'b1101_0110;
        n_exp = SA ? 8 : 5;
        got = 0;
        c = 0;
        while (got < n_exp && c < 300) begin
          @(negedge cp);
          Ack_in = pat[c % 8];
          c++;
          if (Send_out && Ack_in) begin
            if (q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL b2b extra output: got %h expected none", PACKET_OUT);
            end else begin
              e = q.pop_front();
              chk($sformatf("b2b out%0d", got), PACKET_OUT, e);
            end
            got++;
          end
        end
        if (got < n_exp) begin
          n_tests++; n_fail++;
          $display("FAIL b2b outputs: got %0d expected %0d", got, n_exp);
        end
      end
    join
    Ack_in = 1'b1;
    repeat (3) @(negedge cp);
    chk("b2b drained send_out", 40'(Send_out), 40'h0);
    chk("b2b queue empty", 40'(q.size()), 40'h0);
    chk("b2b driver done", 40'(drv_done), 40'h1);
    Ack_in = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
